// File: rtl/usr_seq_shifter.sv
// usr_seq_shifter: multi-cycle shift/rotate/load register, one bit per cycle under a three-state FSM
module usr_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [2:0] M_LOAD = 3'd0;
  localparam logic [2:0] M_ROL  = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_ASR  = 3'd5;
  localparam logic [2:0] M_SHL  = 3'd1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             left, fill, is_shift;
  logic [WIDTH-1:0] step;
  assign left     = mode_q == M_SHL || mode_q == M_ROL;
  assign fill     = mode_q == M_ROL ? dout_q[WIDTH-1] :
                    mode_q == M_ROR ? dout_q[0] :
                    mode_q == M_ASR ? dout_q[WIDTH-1] : sin;
  assign step     = left ? {dout_q[WIDTH-2:0], fill} : {fill, dout_q[WIDTH-1:1]};
  assign is_shift = mode != M_LOAD && mode < 3'd6;
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (state_q == IDLE && start) begin
      dout_d  = mode == M_LOAD ? load_val : dout_q;
      state_d = (is_shift && amt != '0) ? SHIFT : DONE;
      cnt_d   = (is_shift && amt != '0) ? amt : cnt_q;
      mode_d  = (is_shift && amt != '0) ? mode : mode_q;
    end else if (state_q == SHIFT) begin
      dout_d  = step;
      sout_d  = left ? dout_q[WIDTH-1] : dout_q[0];
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == AMT_W'(1) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign dout = dout_q;
  assign sout = sout_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_usr_seq_shifter.sv
// tb_usr_seq_shifter: directed scenario tasks with hand-computed expectations for usr_seq_shifter
module tb_usr_seq_shifter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [4:0]  amt = 5'd0;
  logic [31:0] load_val = 32'd0;
  logic        sin = 1'b0;
  logic [31:0] dout;
  logic        sout, busy, done;
  int errors = 0;
  int checks = 0;
  usr_seq_shifter #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
    .load_val(load_val), .sin(sin), .dout(dout), .sout(sout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [2:0] m, input logic [4:0] a, input logic [31:0] v,
                        output int lat, output int bc);
    @(negedge clk);
    start = 1'b1; mode = m; amt = a; load_val = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bc = 0;
    for (int k = 1; k <= 70; k++) begin
      if (busy) bc++;
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (busy) bc++;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_dout: got %h want %h", dout, 32'd0); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b want 0", sout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk); rst = 1'b1;
  endtask
  task automatic test_shl;
    int lat, bc;
    run_op(3'd0, 5'd7, 32'hA5A50F0F, lat, bc);
    checks++; if (dout !== 32'hA5A50F0F) begin errors++; $display("FAIL load_dout: got %h want %h", dout, 32'hA5A50F0F); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL load_latency: got %0d want 1", lat); end
    sin = 1'b1;
    run_op(3'd1, 5'd4, 32'h0, lat, bc);
    checks++; if (dout !== 32'h5A50F0FF) begin errors++; $display("FAIL shl_dout: got %h want %h", dout, 32'h5A50F0FF); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL shl_sout: got %b want 0", sout); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL shl_latency: got %0d want 5", lat); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL shl_busy_cycles: got %0d want 5", bc); end
    sin = 1'b0;
  endtask
  task automatic test_asr;
    int lat, bc;
    run_op(3'd0, 5'd0, 32'h80000000, lat, bc);
    sin = 1'b1;
    run_op(3'd5, 5'd8, 32'h0, lat, bc);
    checks++; if (dout !== 32'hFF800000) begin errors++; $display("FAIL asr_dout: got %h want %h", dout, 32'hFF800000); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL asr_sout: got %b want 0", sout); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL asr_latency: got %0d want 9", lat); end
    sin = 1'b0;
  endtask
  task automatic test_rotate;
    int lat, bc;
    run_op(3'd0, 5'd0, 32'h12345678, lat, bc);
    run_op(3'd4, 5'd4, 32'h0, lat, bc);
    checks++; if (dout !== 32'h81234567) begin errors++; $display("FAIL ror_dout: got %h want %h", dout, 32'h81234567); end
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL ror_sout: got %b want 1", sout); end
    run_op(3'd3, 5'd4, 32'h0, lat, bc);
    checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL rol_dout: got %h want %h", dout, 32'h12345678); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rol_sout: got %b want 0", sout); end
  endtask
  task automatic test_zero_noop;
    int lat, bc;
    run_op(3'd0, 5'd0, 32'h0000BEEF, lat, bc);
    run_op(3'd1, 5'd0, 32'hFFFFFFFF, lat, bc);
    checks++; if (dout !== 32'h0000BEEF) begin errors++; $display("FAIL amt0_dout: got %h want %h", dout, 32'h0000BEEF); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL amt0_latency: got %0d want 1", lat); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL amt0_busy_cycles: got %0d want 1", bc); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL amt0_sout: got %b want 0", sout); end
    run_op(3'd7, 5'd3, 32'hFFFFFFFF, lat, bc);
    checks++; if (dout !== 32'h0000BEEF) begin errors++; $display("FAIL noop_dout: got %h want %h", dout, 32'h0000BEEF); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL noop_latency: got %0d want 1", lat); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL noop_busy_cycles: got %0d want 1", bc); end
  endtask
  task automatic test_ignore;
    int lat, bc;
    run_op(3'd0, 5'd0, 32'hF0F0F0F0, lat, bc);
    sin = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 3'd2; amt = 5'd5; load_val = 32'h0;
    @(posedge clk); #1;
    mode = 3'd0; amt = 5'd1; load_val = 32'h0;
    lat = -1;
    for (int k = 1; k <= 70; k++) begin
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
      mode = (k % 2 == 0) ? 3'd0 : 3'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (lat !== 6) begin errors++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after: got %b want 0", busy); end
    checks++; if (dout !== 32'h07878787) begin errors++; $display("FAIL ignore_dout: got %h want %h", dout, 32'h07878787); end
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL ignore_sout: got %b want 1", sout); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_still_idle: got %b want 0", busy); end
  endtask
  task automatic test_async_reset;
    int lat, bc;
    run_op(3'd0, 5'd0, 32'hFFFF0000, lat, bc);
    @(negedge clk);
    start = 1'b1; mode = 3'd1; amt = 5'd10; sin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL async_dout: got %h want %h", dout, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done: got %b want 0", done); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL async_sout: got %b want 0", sout); end
    @(negedge clk); rst = 1'b1; sin = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_resume_busy: got %b want 0", busy); end
    run_op(3'd0, 5'd9, 32'h00000001, lat, bc);
    checks++; if (dout !== 32'h00000001) begin errors++; $display("FAIL post_reset_load_dout: got %h want %h", dout, 32'h1); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL post_reset_load_latency: got %0d want 1", lat); end
  endtask
  initial begin
    test_reset;
    test_shl;
    test_asr;
    test_rotate;
    test_zero_noop;
    test_ignore;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
